// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared operation encodings and default threshold helpers for fifo_ctrl_level
package fifo_pkg;

  typedef enum logic [1:0] {
    NOP        = 2'b00,
    READ       = 2'b01,
    WRITE      = 2'b10,
    READ_WRITE = 2'b11
  } fifo_op_e;

  // Defaults stay inside the legal threshold ranges even for very shallow FIFOs.
  function automatic int default_af_level(input int addr_width);
    int depth;
    depth = 1 << addr_width;
    return (depth > 4) ? depth - 4 : depth;
  endfunction

  function automatic int default_ae_level(input int addr_width);
    int depth;
    depth = 1 << addr_width;
    return (depth - 1 < 4) ? depth - 1 : 4;
  endfunction

endpackage

// File: rtl/fifo_ctrl_level.sv
// rtl/fifo_ctrl_level.sv - FIFO pointer/occupancy control with level flags, flush and sticky errors
module fifo_ctrl_level
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL   = default_af_level(ADDR_WIDTH),
  parameter int AE_LEVEL   = default_ae_level(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  wr_acc,
  output logic                  rd_acc,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_L    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_L    = AE_LEVEL[ADDR_WIDTH:0];

  if (ADDR_WIDTH < 1) begin : g_bad_aw
    $error("fifo_ctrl_level: ADDR_WIDTH must be at least 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_ctrl_level: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_ctrl_level: AE_LEVEL must lie in 0..DEPTH-1");
  end

  fifo_op_e            op;
  logic                wr_req;
  logic                rd_req;
  logic                ov_evt;
  logic                un_evt;
  logic [ADDR_WIDTH:0] count_next;
  logic [ADDR_WIDTH:0] level;

  assign op     = fifo_op_e'({wr, rd});
  assign wr_req = (op == WRITE) || (op == READ_WRITE);
  assign rd_req = (op == READ)  || (op == READ_WRITE);

  // A read frees a slot in the same cycle, so a full FIFO still takes a paired write.
  assign rd_acc = !flush && rd_req && !empty;
  assign wr_acc = !flush && wr_req && (!full || rd_acc);

  assign ov_evt = wr_req && !wr_acc && !flush;
  assign un_evt = rd_req && !rd_acc && !flush;

  assign count_next = count + (ADDR_WIDTH + 1)'(wr_acc) - (ADDR_WIDTH + 1)'(rd_acc);
  assign level      = flush ? '0 : count_next;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      w_addr       <= '0;
      r_addr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      w_addr       <= flush ? '0 : w_addr + ADDR_WIDTH'(wr_acc);
      r_addr       <= flush ? '0 : r_addr + ADDR_WIDTH'(rd_acc);
      count        <= level;
      // Flags come from the next occupancy so they never lag count.
      full         <= (level == DEPTH_L);
      empty        <= (level == '0);
      almost_full  <= (level >= AF_L);
      almost_empty <= (level <= AE_L);
      overflow     <= (overflow  && !clr_err) || ov_evt;
      underflow    <= (underflow && !clr_err) || un_evt;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_level.sv
// tb/tb_fifo_ctrl_level.sv - directed vector bench for fifo_ctrl_level at DEPTH 8, AF 6, AE 2
module tb_fifo_ctrl_level;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          Reset;
  logic          wr, rd, flush, clr_err;
  logic          wr_acc, rd_acc, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic [AW-1:0] w_addr, r_addr;
  logic          overflow, underflow;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_ctrl_level #(.ADDR_WIDTH(AW), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .Reset(Reset), .wr(wr), .rd(rd), .flush(flush), .clr_err(clr_err),
    .wr_acc(wr_acc), .rd_acc(rd_acc), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .w_addr(w_addr), .r_addr(r_addr), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr, rd, fl, clr;
    logic ewa, era;
    int   ecnt, ew, er;
    logic eov, eun;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic r, logic f, logic c, logic wa, logic ra,
                              int cnt, int wp, int rp, logic ov, logic un);
    vec_t v;
    v.wr = w; v.rd = r; v.fl = f; v.clr = c; v.ewa = wa; v.era = ra;
    v.ecnt = cnt; v.ew = wp; v.er = rp; v.eov = ov; v.eun = un;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(string tag, int cnt, int wp, int rp, logic ov, logic un);
    chk({tag, " count"}, 32'(count), cnt);
    chk({tag, " full"}, full, cnt == 8);
    chk({tag, " empty"}, empty, cnt == 0);
    chk({tag, " almost_full"}, almost_full, cnt >= 6);
    chk({tag, " almost_empty"}, almost_empty, cnt <= 2);
    chk({tag, " w_addr"}, 32'(w_addr), wp);
    chk({tag, " r_addr"}, 32'(r_addr), rp);
    chk({tag, " overflow"}, overflow, ov);
    chk({tag, " underflow"}, underflow, un);
  endtask

  initial begin
    // Fill, overflow at full, clear, paired ops at full, drain.
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, 0, 0, 1, 0, i, i % 8, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++) vecs.push_back(mk(1, 1, 0, 0, 1, 1, 8, i, i, 0, 0));
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8 - i, 4, (4 + i) % 8, 0, 0));
    // Empty: paired op writes only and flags underflow; clear; clear loses to new error.
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 5, 4, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 5, 5, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 5, 5, 0, 1));
    // Fill to 5, then flush with wr held: error flags keep their value.
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(1, 0, 0, 0, 1, 0, i, (5 + i) % 8, 5, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));

    Reset = 1'b1; wr = 0; rd = 0; flush = 0; clr_err = 0;
    repeat (2) @(posedge clk);
    #1 chk_state("reset", 0, 0, 0, 0, 0);
    @(negedge clk) Reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      wr = vecs[i].wr; rd = vecs[i].rd; flush = vecs[i].fl; clr_err = vecs[i].clr;
      #1;
      chk($sformatf("v%0d wr_acc", i), wr_acc, vecs[i].ewa);
      chk($sformatf("v%0d rd_acc", i), rd_acc, vecs[i].era);
      @(posedge clk);
      #1 chk_state($sformatf("v%0d", i), vecs[i].ecnt, vecs[i].ew, vecs[i].er,
                   vecs[i].eov, vecs[i].eun);
    end

    // Mid-burst asynchronous reset: set underflow first so the reset has something to clear.
    @(negedge clk) rd = 1; wr = 0; flush = 0; clr_err = 0;
    @(negedge clk) rd = 0; wr = 1;
    repeat (4) @(posedge clk);
    #1 chk_state("burst", 4, 4, 0, 0, 1);
    #2 Reset = 1'b1;
    #1 chk_state("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk) Reset = 1'b0; wr = 0;
    @(posedge clk);
    #1 chk_state("post_reset", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
